sdram_arbit: RTL and testbench
==============================

Name: sdram_arbit

Overview:
Central arbiter and command multiplexer for the SDRAM controller. It sits between the init, auto-refresh, write and read sub-blocks and the SDRAM pins. After initialisation completes, it grants exactly one client at a time with priority refresh > write > read. It drives the selected client's command, address and bank onto the SDRAM bus.

Parameters:
ADDR_W, 12, SDRAM address width
BANK_W, 2, SDRAM bank address width
TIMEOUT_CYC, 1023, watchdog limit in clk cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
init_addr  in  ADDR_W  init address
flag_init_end  in  1  level, high once init is done
ref_req  in  1  refresh request, level
flag_ref_end  in  1  refresh sequence done
aref_cmd  in  4  refresh command
aref_addr  in  ADDR_W  refresh address (A10 high for precharge-all)
ref_en  out  1  one-cycle refresh grant
wr_req  in  1  write request, level
wr_end  in  1  write burst done
wr_cmd  in  4  write command
wr_addr  in  ADDR_W  write address
wr_bank  in  BANK_W  write bank
wr_en  out  1  one-cycle write grant
rd_req  in  1  read request, level
rd_end  in  1  read burst done
rd_cmd  in  4  read command
rd_addr  in  ADDR_W  read address
rd_bank  in  BANK_W  read bank
rd_en  out  1  one-cycle read grant
sdram_cke  out  1  clock enable
sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n} to pins
sdram_addr  out  ADDR_W  address to pins
sdram_bank  out  BANK_W  bank to pins
err_timeout  out  1  one-cycle watchdog pulse

Behaviour:
- Clock and reset: clk, rst_n asynchronous active-low.
- Reset values: state=INIT; ref_en/wr_en/rd_en=0; sdram_cke=0; err_timeout=0. sdram_cke goes to 1 on the first clk after reset release and stays 1.
- Command encodings: NOP=4'b0111, PRE=4'b0010, AREF=4'b0001.
- State register is binary, 5 states: INIT, ARBIT, AREF, WRITE, READ.
- INIT:
  - Pins = init_cmd / init_addr, bank 0.
  - flag_init_end=1 -> ARBIT.
- ARBIT:
  - Pins = NOP, addr 0, bank 0.
  - ref_req -> AREF; else wr_req -> WRITE; else rd_req -> READ; else stay.
- Grant pulses:
  - The grant pulse (ref_en/wr_en/rd_en) is registered and high for exactly the first cycle in the new state.
  - A grant is never asserted outside ARBIT->X transitions.
- AREF: pins = aref_cmd/aref_addr, bank 0. flag_ref_end -> ARBIT.
- WRITE: pins = wr_cmd/wr_addr/wr_bank. wr_end -> ARBIT.
- READ: pins = rd_cmd/rd_addr/rd_bank. rd_end -> ARBIT.
- Pin mux is combinational from the registered state. Zero added latency relative to client command registers.
- Boundary conditions:
  - Simultaneous ref_req, wr_req and rd_req in ARBIT -> AREF. The write is taken on the next return to ARBIT if still requested.
  - ref_req rising during WRITE/READ is not pre-empting. It is serviced at the next ARBIT, which always lasts at least 1 cycle.
  - An end flag and a new request in the same cycle -> go to ARBIT first; the grant follows one cycle later.
  - End flags arriving in a state other than their owner's are ignored.
  - flag_init_end falling after INIT is ignored.
  - Reset mid-operation returns to INIT immediately, grants drop, and sdram_cke=0.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entering AREF/WRITE/READ and increments each cycle in them.
  - If it reaches TIMEOUT_CYC without the owner's end flag, force ARBIT and pulse err_timeout for 1 cycle.
  - The counter is held at 0 in INIT/ARBIT.
- When undefined: no counter, and err_timeout is tied 0.

Decomposition:
- Package sdram_pkg holds:
  - command localparams CMD_NOP/CMD_PRE/CMD_AREF/CMD_ACT/CMD_WR/CMD_RD;
  - state encodings ST_INIT..ST_READ;
  - default ADDR_W/BANK_W.
- One natural sub-module, sdram_arbit_wdog: the timeout counter, instantiated only under ARB_TIMEOUT_EN.

Test Plan:
- Reset release with flag_init_end low; init_cmd=0010 -> sdram_cmd=0010, sdram_cke=1 after 1 cycle, no grants. Set flag_init_end=1 -> ARBIT next cycle, sdram_cmd=0111.
- In ARBIT, pulse ref_req, wr_req and rd_req together -> ref_en high 1 cycle; aref_cmd 0010 then 0001 appears on pins. flag_ref_end -> ARBIT 1 cycle, then wr_en pulse.
- Write burst with ref_req asserted mid-burst -> no ref_en until after wr_end. ARBIT held exactly 1 cycle, then ref_en.
- wr_end and rd_req in the same cycle -> ARBIT, then rd_en one cycle later. sdram_bank follows rd_bank=2'b10 while in READ.
- Assert rst_n=0 while in READ -> outputs return to reset values asynchronously. After release, INIT is re-entered and no grant fires until flag_init_end.
- With ARB_TIMEOUT_EN and TIMEOUT_CYC=15, grant a write and never assert wr_end -> err_timeout pulses after 15 cycles and the state returns to ARBIT. With the macro undefined, err_timeout stays 0.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: pin command encodings,
// arbiter state encodings and default bus widths.
package sdram_pkg;

    // SDRAM commands as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    // Default bus widths
    localparam int DEF_ADDR_W = 12;
    localparam int DEF_BANK_W = 2;

    // Arbiter states, binary encoded
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_e;

endpackage

// File: rtl/sdram_arbit_wdog.sv
// Watchdog for a granted client: counts cycles spent in a busy state and
// flags expiry when the owner has not finished within TIMEOUT_CYC cycles.
module sdram_arbit_wdog #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_busy,
    input  logic i_end,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    // r_cnt holds the number of completed cycles in the current busy state,
    // so the TIMEOUT_CYC-th busy cycle without an end flag is the expiry.
    assign o_expire = i_busy && !i_end && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Count busy cycles; held at 0 while idle and cleared whenever the owner leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_busy || i_end || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter and command multiplexer. After init it grants one client
// at a time with priority refresh > write > read and routes that client's
// command/address/bank to the pins.
// Optional watchdog: define ARB_TIMEOUT_EN to abort a client that never ends.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int BANK_W      = DEF_BANK_W,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              flag_init_end,
    input  logic              ref_req,
    input  logic              flag_ref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    output logic              ref_en,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BANK_W-1:0] wr_bank,
    output logic              wr_en,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BANK_W-1:0] rd_bank,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BANK_W-1:0] sdram_bank,
    output logic              err_timeout
);

    state_e r_state;
    logic   r_ref_en;
    logic   r_wr_en;
    logic   r_rd_en;
    logic   r_cke;
    logic   w_owner_end;
    logic   w_expire;

    // End flag of whichever client currently owns the bus; others are ignored
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_owner_end = 1'b0;
        case (r_state)
            ST_AREF:  w_owner_end = flag_ref_end;
            ST_WRITE: w_owner_end = wr_end;
            ST_READ:  w_owner_end = rd_end;
            default:  w_owner_end = 1'b0;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    logic w_busy;
    logic r_err;

    assign w_busy      = (r_state == ST_AREF) || (r_state == ST_WRITE) || (r_state == ST_READ);
    assign err_timeout = r_err;

    sdram_arbit_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_busy   (w_busy),
        .i_end    (w_owner_end),
        .o_expire (w_expire)
    );
`else
    assign w_expire    = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Arbitration FSM with registered one-cycle grant pulses and clock enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_INIT;
            r_ref_en <= 1'b0;
            r_wr_en  <= 1'b0;
            r_rd_en  <= 1'b0;
            r_cke    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_err    <= 1'b0;
`endif
        end else begin
            // NOTE: state and registered outputs use non-blocking assignments so every
            // reader in this edge sees the pre-edge values.
            r_cke    <= 1'b1;
            r_ref_en <= 1'b0;
            r_wr_en  <= 1'b0;
            r_rd_en  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_err    <= w_expire;
`endif
            case (r_state)
                ST_INIT: begin
                    if (flag_init_end) r_state <= ST_ARBIT;
                end
                ST_ARBIT: begin
                    if (ref_req) begin
                        r_state  <= ST_AREF;
                        r_ref_en <= 1'b1;
                    end else if (wr_req) begin
                        r_state  <= ST_WRITE;
                        r_wr_en  <= 1'b1;
                    end else if (rd_req) begin
                        r_state  <= ST_READ;
                        r_rd_en  <= 1'b1;
                    end
                end
                ST_AREF, ST_WRITE, ST_READ: begin
                    if (w_owner_end || w_expire) r_state <= ST_ARBIT;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    // Pin mux driven straight from the registered state, no added latency
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = '0;
        case (r_state)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            default: begin
                sdram_cmd  = CMD_NOP;
                sdram_addr = '0;
                sdram_bank = '0;
            end
        endcase
    end

    assign ref_en    = r_ref_en;
    assign wr_en     = r_wr_en;
    assign rd_en     = r_rd_en;
    assign sdram_cke = r_cke;

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against an
// owner-based behavioural model. Honours ARB_TIMEOUT_EN when defined.
module tb_sdram_arbit;

    localparam int ADDR_W      = 12;
    localparam int BANK_W      = 2;
    localparam int TIMEOUT_CYC = 15;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON  = 1'b1;
`else
    localparam bit TIMEOUT_ON  = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        init_cmd;
    logic [ADDR_W-1:0] init_addr;
    logic              flag_init_end;
    logic              ref_req, flag_ref_end;
    logic [3:0]        aref_cmd;
    logic [ADDR_W-1:0] aref_addr;
    logic              ref_en;
    logic              wr_req, wr_end;
    logic [3:0]        wr_cmd;
    logic [ADDR_W-1:0] wr_addr;
    logic [BANK_W-1:0] wr_bank;
    logic              wr_en;
    logic              rd_req, rd_end;
    logic [3:0]        rd_cmd;
    logic [ADDR_W-1:0] rd_addr;
    logic [BANK_W-1:0] rd_bank;
    logic              rd_en;
    logic              sdram_cke;
    logic [3:0]        sdram_cmd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [BANK_W-1:0] sdram_bank;
    logic              err_timeout;

    int g_checks = 0;
    int g_errors = 0;

    sdram_arbit #(
        .ADDR_W      (ADDR_W),
        .BANK_W      (BANK_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_cmd      (init_cmd),
        .init_addr     (init_addr),
        .flag_init_end (flag_init_end),
        .ref_req       (ref_req),
        .flag_ref_end  (flag_ref_end),
        .aref_cmd      (aref_cmd),
        .aref_addr     (aref_addr),
        .ref_en        (ref_en),
        .wr_req        (wr_req),
        .wr_end        (wr_end),
        .wr_cmd        (wr_cmd),
        .wr_addr       (wr_addr),
        .wr_bank       (wr_bank),
        .wr_en         (wr_en),
        .rd_req        (rd_req),
        .rd_end        (rd_end),
        .rd_cmd        (rd_cmd),
        .rd_addr       (rd_addr),
        .rd_bank       (rd_bank),
        .rd_en         (rd_en),
        .sdram_cke     (sdram_cke),
        .sdram_cmd     (sdram_cmd),
        .sdram_addr    (sdram_addr),
        .sdram_bank    (sdram_bank),
        .err_timeout   (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        g_checks++;
        if (act !== exp) begin
            g_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Owner: 0 = nobody (idle arbitration), 1 = refresh, 2 = write, 3 = read.
    bit       m_inited;
    int       m_owner;
    int       m_busy;
    bit [2:0] m_gnt;
    bit       m_cke;
    bit       m_err;

    function automatic bit owner_done(input int owner);
        case (owner)
            1:       return flag_ref_end;
            2:       return wr_end;
            3:       return rd_end;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_inited <= 1'b0;
            m_owner  <= 0;
            m_busy   <= 0;
            m_gnt    <= 3'b000;
            m_cke    <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            m_cke <= 1'b1;
            m_gnt <= 3'b000;
            m_err <= 1'b0;
            if (!m_inited) begin
                if (flag_init_end) m_inited <= 1'b1;
            end else if (m_owner == 0) begin
                m_busy <= 0;
                if (ref_req)      begin m_owner <= 1; m_gnt <= 3'b100; end
                else if (wr_req)  begin m_owner <= 2; m_gnt <= 3'b010; end
                else if (rd_req)  begin m_owner <= 3; m_gnt <= 3'b001; end
            end else if (owner_done(m_owner)) begin
                m_owner <= 0;
            end else if (TIMEOUT_ON && (m_busy + 1 == TIMEOUT_CYC)) begin
                m_owner <= 0;
                m_err   <= 1'b1;
            end else begin
                m_busy <= m_busy + 1;
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model
    always @(negedge clk) begin
        logic [3:0]        e_cmd;
        logic [ADDR_W-1:0] e_addr;
        logic [BANK_W-1:0] e_bank;
        e_cmd = 4'b0111; e_addr = '0; e_bank = '0;
        if (!m_inited) begin
            e_cmd = init_cmd; e_addr = init_addr;
        end else begin
            case (m_owner)
                1: begin e_cmd = aref_cmd; e_addr = aref_addr; end
                2: begin e_cmd = wr_cmd; e_addr = wr_addr; e_bank = wr_bank; end
                3: begin e_cmd = rd_cmd; e_addr = rd_addr; e_bank = rd_bank; end
                default: ;
            endcase
        end
        check("mdl_cmd",    32'(sdram_cmd),  32'(e_cmd));
        check("mdl_addr",   32'(sdram_addr), 32'(e_addr));
        check("mdl_bank",   32'(sdram_bank), 32'(e_bank));
        check("mdl_grants", 32'({ref_en, wr_en, rd_en}), 32'(m_gnt));
        check("mdl_cke",    32'(sdram_cke),  32'(m_cke));
        check("mdl_err",    32'(err_timeout), 32'(m_err));
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic grants_is(input string name, input logic [2:0] exp);
        check(name, 32'({ref_en, wr_en, rd_en}), 32'(exp));
    endtask

    task automatic randomize_inputs();
        init_cmd      = 4'($urandom);
        init_addr     = ADDR_W'($urandom);
        flag_init_end = ($urandom_range(0, 7) != 0);
        ref_req       = ($urandom_range(0, 3) == 0);
        wr_req        = $urandom_range(0, 1) == 1;
        rd_req        = $urandom_range(0, 1) == 1;
        flag_ref_end  = ($urandom_range(0, 3) == 0);
        wr_end        = ($urandom_range(0, 3) == 0);
        rd_end        = ($urandom_range(0, 3) == 0);
        aref_cmd      = 4'($urandom);
        aref_addr     = ADDR_W'($urandom);
        wr_cmd        = 4'($urandom);
        wr_addr       = ADDR_W'($urandom);
        wr_bank       = BANK_W'($urandom);
        rd_cmd        = 4'($urandom);
        rd_addr       = ADDR_W'($urandom);
        rd_bank       = BANK_W'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        init_cmd = 4'b0010; init_addr = 12'h400; flag_init_end = 1'b0;
        ref_req = 0; flag_ref_end = 0; aref_cmd = 4'b0111; aref_addr = '0;
        wr_req = 0; wr_end = 0; wr_cmd = 4'b0100; wr_addr = 12'h123; wr_bank = 2'b01;
        rd_req = 0; rd_end = 0; rd_cmd = 4'b0101; rd_addr = 12'h456; rd_bank = 2'b10;

        // Reset state
        cyc(); cyc();
        check("rst_cke", 32'(sdram_cke), 32'd0);
        grants_is("rst_grants", 3'b000);
        check("rst_err", 32'(err_timeout), 32'd0);

        // Release with init still running
        rst_n = 1'b1;
        cyc();
        check("init_cke", 32'(sdram_cke), 32'd1);
        check("init_cmd", 32'(sdram_cmd), 32'h2);
        check("init_addr", 32'(sdram_addr), 32'h400);
        grants_is("init_grants", 3'b000);

        flag_init_end = 1'b1;
        cyc();
        check("arbit_cmd", 32'(sdram_cmd), 32'h7);
        check("arbit_addr", 32'(sdram_addr), 32'h0);

        // All three requests together: refresh wins
        aref_cmd = 4'b0010; aref_addr = 12'h400;
        ref_req = 1; wr_req = 1; rd_req = 1;
        cyc();
        grants_is("all_req_ref_en", 3'b100);
        check("aref_pre_cmd", 32'(sdram_cmd), 32'h2);
        check("aref_pre_addr", 32'(sdram_addr), 32'h400);
        ref_req = 0; aref_cmd = 4'b0001;
        #1;
        check("aref_ref_cmd", 32'(sdram_cmd), 32'h1);
        cyc();
        grants_is("ref_en_one_cycle", 3'b000);
        flag_ref_end = 1;
        cyc();
        check("after_ref_arbit", 32'(sdram_cmd), 32'h7);
        grants_is("after_ref_no_grant", 3'b000);
        flag_ref_end = 0; rd_req = 0;
        cyc();
        grants_is("pending_wr_en", 3'b010);
        check("wr_bank", 32'(sdram_bank), 32'h1);

        // Refresh request mid-burst does not pre-empt
        ref_req = 1;
        cyc(); cyc();
        grants_is("no_preempt", 3'b000);
        check("still_write", 32'(sdram_cmd), 32'h4);
        wr_end = 1;
        cyc();
        check("arbit_one_cycle", 32'(sdram_cmd), 32'h7);
        grants_is("arbit_one_cycle_gnt", 3'b000);
        wr_end = 0; wr_req = 0;
        cyc();
        grants_is("deferred_ref_en", 3'b100);
        ref_req = 0; flag_ref_end = 1;
        cyc();
        flag_ref_end = 0; wr_req = 1;
        cyc();
        grants_is("wr_en_again", 3'b010);

        // End flag and new request in the same cycle
        wr_req = 0; wr_end = 1; rd_req = 1;
        cyc();
        grants_is("end_then_arbit", 3'b000);
        check("end_then_arbit_cmd", 32'(sdram_cmd), 32'h7);
        wr_end = 0;
        cyc();
        grants_is("rd_en_late", 3'b001);
        check("rd_bank", 32'(sdram_bank), 32'h2);
        check("rd_cmd", 32'(sdram_cmd), 32'h5);
        cyc();
        check("rd_bank_hold", 32'(sdram_bank), 32'h2);

        // Asynchronous reset in READ
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cke", 32'(sdram_cke), 32'd0);
        grants_is("async_rst_grants", 3'b000);
        check("async_rst_cmd", 32'(sdram_cmd), 32'h2);
        flag_init_end = 0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            grants_is("no_grant_before_init", 3'b000);
        end
        flag_init_end = 1; rd_req = 0;
        cyc();
        flag_init_end = 0;   // falling after init is ignored
        cyc();
        check("init_fall_ignored", 32'(sdram_cmd), 32'h7);

`ifdef ARB_TIMEOUT_EN
        // Write that never ends trips the watchdog
        wr_req = 1;
        cyc();
        grants_is("wdog_wr_en", 3'b010);
        wr_req = 0;
        for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
            cyc();
            check("wdog_quiet", 32'(err_timeout), 32'd0);
        end
        cyc();
        check("wdog_pulse", 32'(err_timeout), 32'd1);
        check("wdog_arbit", 32'(sdram_cmd), 32'h7);
        cyc();
        check("wdog_pulse_end", 32'(err_timeout), 32'd0);
`endif

        // Randomized traffic, checked by the compare process
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                check("rand_rst_cke", 32'(sdram_cke), 32'd0);
                cyc();
                rst_n = 1'b1;
            end else begin
                cyc();
            end
        end

        $display("CHECKS %0d ERRORS %0d", g_checks, g_errors);
        $finish;
    end

endmodule
